// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, optional debounce filter and edge detector.
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous, active-high
//   in       - WIDTH asynchronous raw inputs
//   out      - WIDTH synchronized (and debounced) levels
//   rise     - WIDTH one-cycle pulses on 0->1 of out
//   fall     - WIDTH one-cycle pulses on 1->0 of out
//   changed  - any rise or fall this cycle
module input_conditioner #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter int unsigned      DEBOUNCE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (STAGES < 2) begin : g_bad_stages
        $error("input_conditioner: STAGES must be at least 2");
    end

    // Synchronizer chain; stage 0 is the only flop that sees raw input.
    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]             sync;
    logic [WIDTH-1:0]             lvl;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync = sync_q[STAGES-1];

    if (DEBOUNCE == 0) begin : g_bypass
        assign lvl = sync;
    end else begin : g_filter
        localparam int CW = ($clog2(DEBOUNCE + 1) < 1) ? 1 : $clog2(DEBOUNCE + 1);
        localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

        logic [WIDTH-1:0][CW-1:0] cnt_q;
        logic [WIDTH-1:0][CW-1:0] cnt_d;
        logic [WIDTH-1:0]         lvl_q;
        logic [WIDTH-1:0]         lvl_d;

        // cnt counts consecutive cycles where sync disagrees with the
        // filtered level; any agreement restarts the count.
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == lvl_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    lvl_d[i] = sync[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= RESET_VAL;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign lvl = lvl_q;
    end

    // Edge detector on the conditioned level.
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = lvl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Pulses are masked while reset is asserted so they are quiet even
    // before the first reset edge has loaded the registers.
    assign out     = lvl;
    assign rise    = lvl & ~prev_q & ~{WIDTH{reset}};
    assign fall    = ~lvl & prev_q & ~{WIDTH{reset}};
    assign changed = |(rise | fall);

endmodule
